// File: rtl/ysyx_22041211_wbu_if.sv
// Bundle of EXU->WBU, LSU->WBU and WBU write-back/commit signals.
// master: the side that issues instructions and load responses; slave: the WBU.
interface ysyx_22041211_wbu_if #(
  parameter int DATA_LEN = 32,
  parameter int REG_AW   = 5
);
  logic                exu_valid_i;
  logic                exu_ready_o;
  logic [DATA_LEN-1:0] exu_pc_i;
  logic                exu_wd_i;
  logic [REG_AW-1:0]   exu_wreg_i;
  logic [DATA_LEN-1:0] exu_wdata_i;
  logic                exu_csr_we_i;
  logic [DATA_LEN-1:0] exu_csr_wdata_i;
  logic                exu_mem_i;
  logic                lsu_valid_i;
  logic [DATA_LEN-1:0] lsu_rdata_i;
  logic                wd_o;
  logic [REG_AW-1:0]   wreg_o;
  logic [DATA_LEN-1:0] wdata_o;
  logic                csr_we_o;
  logic [DATA_LEN-1:0] csr_wdata_o;
  logic                commit_o;
  logic [DATA_LEN-1:0] commit_pc_o;
  logic                timeout_o;

  modport master (
    output exu_valid_i, exu_pc_i, exu_wd_i, exu_wreg_i, exu_wdata_i,
           exu_csr_we_i, exu_csr_wdata_i, exu_mem_i, lsu_valid_i, lsu_rdata_i,
    input  exu_ready_o, wd_o, wreg_o, wdata_o, csr_we_o, csr_wdata_o,
           commit_o, commit_pc_o, timeout_o
  );

  modport slave (
    input  exu_valid_i, exu_pc_i, exu_wd_i, exu_wreg_i, exu_wdata_i,
           exu_csr_we_i, exu_csr_wdata_i, exu_mem_i, lsu_valid_i, lsu_rdata_i,
    output exu_ready_o, wd_o, wreg_o, wdata_o, csr_we_o, csr_wdata_o,
           commit_o, commit_pc_o, timeout_o
  );
endinterface

// File: rtl/ysyx_22041211_wbu.sv
// Write-back unit: captures one EXU result, optionally waits for LSU load data, retires it.
// Define YSYX_22041211_WB_RETIRE_CNT_EN to add the 64-bit retire_cnt_o counter port.
module ysyx_22041211_wbu #(
  parameter int DATA_LEN    = 32,
  parameter int REG_AW      = 5,
  parameter int TIMEOUT_CYC = 255
) (
  input  logic                clk,
  input  logic                rst,
  ysyx_22041211_wbu_if.slave  wb
`ifdef YSYX_22041211_WB_RETIRE_CNT_EN
  ,
  output logic [63:0]         retire_cnt_o
`endif
);

  typedef enum logic [1:0] {S_IDLE, S_WAIT_MEM, S_COMMIT} state_t;

  localparam logic [15:0] LIMIT = 16'(TIMEOUT_CYC - 1);

  state_t              r_state;
  state_t              w_next;
  logic [DATA_LEN-1:0] r_pc;
  logic [DATA_LEN-1:0] r_wdata;
  logic [DATA_LEN-1:0] r_csr_wdata;
  logic                r_wd;
  logic                r_csr_we;
  logic [REG_AW-1:0]   r_wreg;
  logic [15:0]         r_cnt;
  logic                r_timeout;
  logic                w_xfer;
  logic                w_load;
  logic                w_set_timeout;
  logic                w_commit;

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  // lsu_valid_i is checked before the limit so a response on the last cycle still commits
  always_comb begin
    w_next        = r_state;
    w_xfer        = 1'b0;
    w_load        = 1'b0;
    w_set_timeout = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (wb.exu_valid_i) begin
          w_xfer = 1'b1;
          w_next = wb.exu_mem_i ? S_WAIT_MEM : S_COMMIT;
        end
      end
      S_WAIT_MEM: begin
        if (wb.lsu_valid_i) begin
          w_load = 1'b1;
          w_next = S_COMMIT;
        end else if (r_cnt == LIMIT) begin
          w_set_timeout = 1'b1;
          w_next        = S_IDLE;
        end
      end
      S_COMMIT: w_next = S_IDLE;
      default:  w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_pc        <= '0;
      r_wd        <= 1'b0;
      r_wreg      <= '0;
      r_wdata     <= '0;
      r_csr_we    <= 1'b0;
      r_csr_wdata <= '0;
      r_cnt       <= '0;
      r_timeout   <= 1'b0;
    end else begin
      if (w_xfer) begin
        r_pc        <= wb.exu_pc_i;
        r_wd        <= wb.exu_wd_i;
        r_wreg      <= wb.exu_wreg_i;
        r_wdata     <= wb.exu_wdata_i;
        r_csr_we    <= wb.exu_csr_we_i;
        r_csr_wdata <= wb.exu_csr_wdata_i;
        r_cnt       <= '0;
      end else if (r_state == S_WAIT_MEM) begin
        r_cnt <= r_cnt + 16'd1;
      end
      if (w_load)        r_wdata   <= wb.lsu_rdata_i;
      if (w_set_timeout) r_timeout <= 1'b1;
    end
  end

  // Outputs are gated by rst so they read 0 even in the cycle reset is first applied
  always_comb begin
    w_commit       = (r_state == S_COMMIT) && !rst;
    wb.exu_ready_o = (r_state == S_IDLE);
    wb.commit_o    = w_commit;
    wb.commit_pc_o = w_commit ? r_pc : '0;
    wb.wd_o        = w_commit && r_wd && (r_wreg != '0);
    wb.wreg_o      = w_commit ? r_wreg : '0;
    wb.wdata_o     = w_commit ? r_wdata : '0;
    wb.csr_we_o    = w_commit && r_csr_we;
    wb.csr_wdata_o = w_commit ? r_csr_wdata : '0;
    wb.timeout_o   = r_timeout && !rst;
  end

`ifdef YSYX_22041211_WB_RETIRE_CNT_EN
  logic [63:0] r_retire_cnt;

  always_ff @(posedge clk) begin
    if (rst)                        r_retire_cnt <= '0;
    else if (r_state == S_COMMIT)   r_retire_cnt <= r_retire_cnt + 64'd1;
  end

  assign retire_cnt_o = r_retire_cnt;
`endif

endmodule

// File: tb/tb_ysyx_22041211_wbu.sv
// Bench for ysyx_22041211_wbu: per-cycle expectation table filled from transaction-level rules,
// checked every cycle on the falling edge, plus literal pins on key cycles.
module tb_ysyx_22041211_wbu;
  localparam int TO = 4;
  localparam int N  = 1024;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  ysyx_22041211_wbu_if #(.DATA_LEN(32), .REG_AW(5)) bus ();

`ifdef YSYX_22041211_WB_RETIRE_CNT_EN
  logic [63:0] retire_cnt;
`endif

  ysyx_22041211_wbu #(
    .DATA_LEN(32),
    .REG_AW(5),
    .TIMEOUT_CYC(TO)
  ) dut (
    .clk(clk),
    .rst(rst),
    .wb(bus)
`ifdef YSYX_22041211_WB_RETIRE_CNT_EN
    ,
    .retire_cnt_o(retire_cnt)
`endif
  );

  typedef struct {
    logic        chk_ready;
    logic        ready;
    logic        commit;
    logic        wd;
    logic [4:0]  wreg;
    logic [31:0] wdata;
    logic        csr_we;
    logic [31:0] csr_wdata;
    logic [31:0] pc;
    logic        timeout;
  } exp_t;

  typedef struct {
    int          c;
    logic        ready;
    logic        commit;
    logic        wd;
    logic [31:0] wdata;
    logic        timeout;
  } pin_t;

  exp_t    exp_tab [N];
  pin_t    pins [$];
  exp_t    ce;
  int      cyc = 0;
  int      total = 0;
  int      bad = 0;
  longint  exp_retire = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(string name, logic [63:0] act, logic [63:0] expv);
    total++;
    if (act !== expv) begin
      bad++;
      $display("FAIL %s cyc=%0d actual=%0h required=%0h", name, cyc, act, expv);
    end
  endtask

  always @(negedge clk) begin
    if (cyc < N) begin
      ce = exp_tab[cyc];
      if (ce.chk_ready) chk("ready", 64'(bus.exu_ready_o), 64'(ce.ready));
      chk("commit",    64'(bus.commit_o),    64'(ce.commit));
      chk("wd",        64'(bus.wd_o),        64'(ce.wd));
      chk("wreg",      64'(bus.wreg_o),      64'(ce.wreg));
      chk("wdata",     64'(bus.wdata_o),     64'(ce.wdata));
      chk("csr_we",    64'(bus.csr_we_o),    64'(ce.csr_we));
      chk("csr_wdata", 64'(bus.csr_wdata_o), 64'(ce.csr_wdata));
      chk("commit_pc", 64'(bus.commit_pc_o), 64'(ce.pc));
      chk("timeout",   64'(bus.timeout_o),   64'(ce.timeout));
      foreach (pins[i]) begin
        if (pins[i].c == cyc) begin
          chk("pin_ready",   64'(bus.exu_ready_o), 64'(pins[i].ready));
          chk("pin_commit",  64'(bus.commit_o),    64'(pins[i].commit));
          chk("pin_wd",      64'(bus.wd_o),        64'(pins[i].wd));
          chk("pin_wdata",   64'(bus.wdata_o),     64'(pins[i].wdata));
          chk("pin_timeout", 64'(bus.timeout_o),   64'(pins[i].timeout));
        end
      end
    end
  end

  // ---------------- model: what each cycle must show ----------------
  function automatic void sched_commit(int c, logic [31:0] pc, logic wd, logic [4:0] wreg,
                                       logic [31:0] wdata, logic csr_we, logic [31:0] csr_wdata);
    exp_tab[c].ready     = 1'b0;
    exp_tab[c].commit    = 1'b1;
    exp_tab[c].wd        = wd && (wreg != 5'd0);
    exp_tab[c].wreg      = wreg;
    exp_tab[c].wdata     = wdata;
    exp_tab[c].csr_we    = csr_we;
    exp_tab[c].csr_wdata = csr_wdata;
    exp_tab[c].pc        = pc;
    exp_retire++;
  endfunction

  function automatic void sched_timeout(int c);
    for (int i = c; i < N; i++) exp_tab[i].timeout = 1'b1;
  endfunction

  function automatic void set_reset(int c);
    exp_tab[c].chk_ready = 1'b0;
    exp_tab[c].ready     = 1'b0;
    exp_tab[c].commit    = 1'b0;
    exp_tab[c].wd        = 1'b0;
    exp_tab[c].wreg      = '0;
    exp_tab[c].wdata     = '0;
    exp_tab[c].csr_we    = 1'b0;
    exp_tab[c].csr_wdata = '0;
    exp_tab[c].pc        = '0;
    for (int i = c; i < N; i++) exp_tab[i].timeout = 1'b0;
    exp_retire = 0;
  endfunction

  function automatic void pin(int c, logic ready, logic commit, logic wd, logic [31:0] wdata,
                              logic timeout);
    pin_t p;
    p.c = c; p.ready = ready; p.commit = commit; p.wd = wd; p.wdata = wdata; p.timeout = timeout;
    pins.push_back(p);
  endfunction

  // ---------------- stimulus ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_exu(logic v, logic [31:0] pc, logic wd, logic [4:0] wreg,
                           logic [31:0] wdata, logic csr_we, logic [31:0] csr_wdata, logic mem);
    bus.exu_valid_i     = v;
    bus.exu_pc_i        = pc;
    bus.exu_wd_i        = wd;
    bus.exu_wreg_i      = wreg;
    bus.exu_wdata_i     = wdata;
    bus.exu_csr_we_i    = csr_we;
    bus.exu_csr_wdata_i = csr_wdata;
    bus.exu_mem_i       = mem;
  endtask

  task automatic quiet();
    drive_exu(1'b0, '0, 1'b0, '0, '0, 1'b0, '0, 1'b0);
    bus.lsu_valid_i = 1'b0;
    bus.lsu_rdata_i = '0;
  endtask

  // valid held high with junk while the WBU is busy: must neither transfer nor alter the capture
  task automatic garbage();
    drive_exu(1'b1, $urandom, 1'($urandom), 5'($urandom), $urandom, 1'($urandom), $urandom,
              1'($urandom));
  endtask

  task automatic idle(int n, logic lsu);
    for (int i = 0; i < n; i++) begin
      quiet();
      bus.lsu_valid_i = lsu;
      bus.lsu_rdata_i = $urandom;
      step();
    end
    quiet();
  endtask

  task automatic alu(logic [31:0] pc, logic wd, logic [4:0] wreg, logic [31:0] wdata,
                     logic csr_we, logic [31:0] csr_wdata);
    int t = cyc;
    drive_exu(1'b1, pc, wd, wreg, wdata, csr_we, csr_wdata, 1'b0);
    sched_commit(t + 1, pc, wd, wreg, wdata, csr_we, csr_wdata);
    step();
    garbage();
    bus.lsu_valid_i = 1'b1;
    bus.lsu_rdata_i = $urandom;
    step();
    quiet();
  endtask

  // d = WAIT_MEM cycle (1-based) carrying lsu_valid_i; d = 0 means no response at all
  task automatic mem(logic [31:0] pc, logic wd, logic [4:0] wreg, logic [31:0] wdata,
                     logic csr_we, logic [31:0] csr_wdata, int d, logic [31:0] rdata);
    int t = cyc;
    drive_exu(1'b1, pc, wd, wreg, wdata, csr_we, csr_wdata, 1'b1);
    step();
    if (d > 0) begin
      for (int k = 1; k <= d; k++) begin
        exp_tab[t + k].ready = 1'b0;
        garbage();
        bus.lsu_valid_i = (k == d);
        bus.lsu_rdata_i = (k == d) ? rdata : $urandom;
        step();
      end
      sched_commit(t + d + 1, pc, wd, wreg, rdata, csr_we, csr_wdata);
      garbage();
      bus.lsu_valid_i = 1'b1;
      bus.lsu_rdata_i = $urandom;
      step();
    end else begin
      for (int k = 1; k <= TO; k++) begin
        exp_tab[t + k].ready = 1'b0;
        garbage();
        bus.lsu_valid_i = 1'b0;
        step();
      end
      sched_timeout(t + TO + 1);
    end
    quiet();
  endtask

  initial begin
    int t;
    for (int i = 0; i < N; i++) begin
      exp_tab[i].chk_ready = 1'b1;
      exp_tab[i].ready     = 1'b1;
      exp_tab[i].commit    = 1'b0;
      exp_tab[i].wd        = 1'b0;
      exp_tab[i].wreg      = '0;
      exp_tab[i].wdata     = '0;
      exp_tab[i].csr_we    = 1'b0;
      exp_tab[i].csr_wdata = '0;
      exp_tab[i].pc        = '0;
      exp_tab[i].timeout   = 1'b0;
    end
    quiet();
    rst = 1'b1;
    set_reset(0); set_reset(1); set_reset(2);
    step(); step(); step();
    rst = 1'b0;
    pin(cyc, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0);

    // simple ALU write, then all-zero cycle after
    pin(cyc + 1, 1'b0, 1'b1, 1'b1, 32'h0000_1234, 1'b0);
    pin(cyc + 2, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
    alu(32'h8000_0000, 1'b1, 5'd5, 32'h0000_1234, 1'b0, 32'h0);

    // x0 write suppressed, CSR still written
    pin(cyc + 1, 1'b0, 1'b1, 1'b0, 32'h0000_0055, 1'b0);
    alu(32'h8000_0004, 1'b1, 5'd0, 32'h0000_0055, 1'b1, 32'h0000_0088);

    for (int i = 0; i < 10; i++)
      alu(32'h8000_0100 + 32'(4 * i), 1'b1, 5'(i + 1), 32'(i * 17 + 3), 1'(i), 32'(i));

    // load answered on 3rd wait cycle; CSR data must not be replaced
    pin(cyc + 3, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
    pin(cyc + 4, 1'b0, 1'b1, 1'b1, 32'hDEAD_BEEF, 1'b0);
    mem(32'h8000_0200, 1'b1, 5'd7, 32'h0000_1111, 1'b1, 32'h0000_0099, 3, 32'hDEAD_BEEF);

    mem(32'h8000_0204, 1'b1, 5'd3, 32'h0000_2222, 1'b0, 32'h0, 1, 32'hCAFE_0001);

    // response on the very last allowed wait cycle wins over timeout
    pin(cyc + 5, 1'b0, 1'b1, 1'b1, 32'hA5A5_A5A5, 1'b0);
    mem(32'h8000_0208, 1'b1, 5'd9, 32'h0000_3333, 1'b0, 32'h0, TO, 32'hA5A5_A5A5);

    idle(3, 1'b1);

    // no response: timeout, no commit
    pin(cyc + 4, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
    pin(cyc + 5, 1'b1, 1'b0, 1'b0, 32'h0, 1'b1);
    mem(32'h8000_020C, 1'b1, 5'd11, 32'h0000_4444, 1'b0, 32'h0, 0, 32'h0);

    pin(cyc + 1, 1'b0, 1'b1, 1'b1, 32'h0000_0077, 1'b1);
    alu(32'h8000_0210, 1'b1, 5'd2, 32'h0000_0077, 1'b0, 32'h0);
    idle(2, 1'b0);

    // reset during WAIT_MEM, then a late response
    t = cyc;
    drive_exu(1'b1, 32'h8000_0300, 1'b1, 5'd4, 32'h0000_0010, 1'b0, 32'h0, 1'b1);
    step();
    exp_tab[t + 1].ready = 1'b0;
    garbage();
    bus.lsu_valid_i = 1'b0;
    step();
    rst = 1'b1;
    quiet();
    set_reset(t + 2);
    step();
    rst = 1'b0;
    bus.lsu_valid_i = 1'b1;
    bus.lsu_rdata_i = 32'hBAD0_BAD0;
    pin(t + 3, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
    pin(t + 4, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
    step();
    idle(2, 1'b0);

    // reset in the COMMIT cycle: outputs held at 0, no later commit
    t = cyc;
    drive_exu(1'b1, 32'h8000_0400, 1'b1, 5'd6, 32'h0000_0066, 1'b1, 32'h0000_0006, 1'b0);
    step();
    rst = 1'b1;
    quiet();
    set_reset(t + 1);
    step();
    rst = 1'b0;
    pin(t + 2, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
    idle(2, 1'b0);

    for (int i = 0; i < 10; i++)
      alu(32'h8000_0500 + 32'(4 * i), 1'b1, 5'(31 - i), 32'hF000_0000 | 32'(i), 1'b0, 32'h0);
    idle(3, 1'b0);

`ifdef YSYX_22041211_WB_RETIRE_CNT_EN
    chk("retire_cnt", retire_cnt, 64'(exp_retire));
`endif

    @(negedge clk);
    #1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/ysyx_22041211_wbu.md
YSYX_22041211_WBU -- requirements
Module: ysyx_22041211_wbu

Interface
REQ-001 SHALL have parameter DATA_LEN, default 32: width of every data, PC and CSR bus.
REQ-002 SHALL have parameter REG_AW, default 5: register address width (4 for RV32E).
REQ-003 SHALL have parameter TIMEOUT_CYC, default 255: maximum number of WAIT_MEM cycles; legal range 1..65535.
REQ-004 SHALL have ports clk in 1 (clock, all state on posedge) and rst in 1 (reset, synchronous, active-high).
REQ-005 SHALL have exu_valid_i in 1 (EXU result valid) and exu_ready_o out 1 (WBU can accept).
REQ-006 SHALL have exu_pc_i in DATA_LEN (instruction PC) and exu_wd_i in 1 (GPR write enable).
REQ-007 SHALL have exu_wreg_i in REG_AW (destination register) and exu_wdata_i in DATA_LEN (ALU result).
REQ-008 SHALL have exu_csr_we_i in 1 and exu_csr_wdata_i in DATA_LEN (CSR write request and data).
REQ-009 SHALL have exu_mem_i in 1 (memory instruction; LSU response required).
REQ-010 SHALL have lsu_valid_i in 1 (LSU response) and lsu_rdata_i in DATA_LEN (load data).
REQ-011 SHALL have wd_o out 1, wreg_o out REG_AW and wdata_o out DATA_LEN (GPR write port).
REQ-012 SHALL have csr_we_o out 1 and csr_wdata_o out DATA_LEN (CSR write port).
REQ-013 SHALL have commit_o out 1 (instruction retired) and commit_pc_o out DATA_LEN (PC of the retired instruction).
REQ-014 SHALL have timeout_o out 1 (sticky LSU-timeout error).

Function
REQ-015 SHALL implement a registered FSM with three states: IDLE, WAIT_MEM, COMMIT.
REQ-016 SHALL drive exu_ready_o high only in IDLE; a transfer occurs when exu_valid_i and exu_ready_o are both high.
REQ-017 SHALL register all exu_* fields on a transfer; later changes to the inputs SHALL NOT alter the captured instruction.
REQ-018 SHALL go IDLE->COMMIT on a transfer with exu_mem_i=0, and IDLE->WAIT_MEM on a transfer with exu_mem_i=1.
REQ-019 In WAIT_MEM, lsu_valid_i=1 SHALL capture lsu_rdata_i and move the FSM to COMMIT.
REQ-020 Captured load data SHALL replace exu_wdata_i for the GPR write; captured load data SHALL NOT replace CSR data.
REQ-021 SHALL ignore lsu_valid_i in IDLE and COMMIT.
REQ-022 SHALL hold COMMIT for exactly one cycle and then return to IDLE; commit_o is high only in COMMIT.
REQ-023 Latency: transfer at cycle T with exu_mem_i=0 SHALL give commit_o at T+1; lsu_valid_i at cycle L SHALL give commit_o at L+1.
REQ-024 Throughput: at most one instruction per two cycles.
REQ-025 SHALL drive wd_o, wreg_o, wdata_o, csr_we_o, csr_wdata_o and commit_pc_o from captured values in COMMIT, and to 0 otherwise.
REQ-026 SHALL force wd_o to 0 when the captured wreg is 0 (x0 write suppression); commit_o SHALL still assert.
REQ-027 SHALL count WAIT_MEM cycles with a 16-bit counter that is cleared on entry to WAIT_MEM.
REQ-028 When the count reaches TIMEOUT_CYC without lsu_valid_i, SHALL set timeout_o, return to IDLE and not commit.
REQ-029 If lsu_valid_i arrives in the same cycle the limit is reached, the response SHALL win: normal commit and timeout_o unchanged.
REQ-030 Once set, timeout_o SHALL stay high until rst.

Reset
REQ-031 SHALL, while rst is high, put the FSM in IDLE, clear the counter and all captured registers, and clear timeout_o.
REQ-032 SHALL hold all outputs at 0 during reset, except exu_ready_o.
REQ-033 A reset in WAIT_MEM or COMMIT SHALL abort the instruction, with no commit after release.
REQ-034 exu_ready_o SHALL be 1 in the first cycle after reset is released.

Configuration
REQ-035 With macro YSYX_22041211_WB_RETIRE_CNT_EN defined, SHALL add port retire_cnt_o out 64 (retired-instruction count).
REQ-036 With the macro defined, retire_cnt_o SHALL reset to 0, increment once per commit_o cycle and wrap modulo 2^64.
REQ-037 Without the macro, the port and the counter SHALL be absent; all other behaviour is identical.

Verification
REQ-038 Transfer with pc=0x80000000, wd=1, wreg=5, wdata=0x1234, mem=0 -> next cycle commit_o=1, wd_o=1, wreg_o=5, wdata_o=0x1234, commit_pc_o=0x80000000, and all outputs 0 in the cycle after.
REQ-039 Transfer with mem=1, wreg=7; lsu_valid_i=1 with lsu_rdata_i=0xDEADBEEF three cycles later -> commit_o one cycle after lsu_valid_i, wdata_o=0xDEADBEEF, and exu_ready_o=0 throughout.
REQ-040 Transfer with wreg=0, wd=1, csr_we=1, csr_wdata=0x88 -> commit_o=1, wd_o=0, csr_we_o=1, csr_wdata_o=0x88.
REQ-041 With TIMEOUT_CYC=4, mem=1 and no lsu_valid_i -> timeout_o rises after 4 WAIT_MEM cycles and no commit occurs; a repeat with lsu_valid_i on the 4th cycle -> commit occurs and timeout_o=0.
REQ-042 rst asserted while in WAIT_MEM, then a late lsu_valid_i -> no commit_o and exu_ready_o=1 after release; with the macro defined, 10 back-to-back commits -> retire_cnt_o=10.
